// File: rtl/seg7_multi_driver.sv
// Multi-digit seven-segment driver: sequential double-dabble binary-to-BCD conversion
// (one bit per clock) feeding registered BCD and active-low segment outputs.
module seg7_multi_driver #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DIGITS   = 5,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int unsigned AccW = 4 * DIGITS;
    localparam int unsigned SegW = 7 * DIGITS;
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam int unsigned CmpW = (WIDTH > 32) ? WIDTH : 32;

    localparam logic [6:0] SegBlank = 7'b1111111;
    localparam logic [6:0] SegDash  = 7'b0111111;
    localparam logic [6:0] SegZero  = 7'b1000000;

    function automatic logic [31:0] max_value(input int unsigned n);
        logic [31:0] v;
        v = 32'd1;
        for (int unsigned i = 0; i < n; i++) begin
            v = v * 32'd10;
        end
        return v - 32'd1;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0011000;
            default: s = SegBlank;
        endcase
        return s;
    endfunction

    function automatic logic [SegW-1:0] seg_reset();
        logic [SegW-1:0] s;
        for (int k = 0; k < int'(DIGITS); k++) begin
            s[7*k +: 7] = (k == 0 || !BLANK_LZ) ? SegZero : SegBlank;
        end
        return s;
    endfunction

    localparam logic [CmpW-1:0] MaxValExt = CmpW'(max_value(DIGITS));
    localparam logic [SegW-1:0] SegReset  = seg_reset();

    typedef enum logic [0:0] {StIdle, StConv} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [AccW-1:0]   acc_q, acc_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              ovf_next_q, ovf_next_d;

    logic [AccW-1:0]   bcd_q;
    logic [SegW-1:0]   seg_q, seg_next;
    logic              ovf_q, done_q;

    logic              accept, last, iterate;
    logic [AccW-1:0]   adj;
    logic              lead;
    logic [3:0]        digit;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StConv;
            StConv:  if (last)  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM-decoded controls
    always_comb begin
        busy    = (state_q == StConv);
        accept  = (state_q == StIdle) && start;
        last    = (state_q == StConv) && (cnt_q == CntW'(WIDTH));
        iterate = (state_q == StConv) && !last;
    end

    // Double-dabble datapath: WIDTH iterations, then one cycle to publish the result.
    always_comb begin
        shift_d    = shift_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_next_d = ovf_next_q;
        adj        = acc_q;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (adj[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
            end
        end
        if (accept) begin
            shift_d    = bin;
            acc_d      = '0;
            cnt_d      = '0;
            ovf_next_d = (CmpW'(bin) > MaxValExt);
        end else if (iterate) begin
            // Top accumulator bit falls off; overflow flag covers that case.
            {acc_d, shift_d} = {adj, shift_q} << 1;
            cnt_d            = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_next_q <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_next_q <= ovf_next_d;
        end
    end

    // Segment image of the finished accumulator, scanning from the top digit down.
    always_comb begin
        seg_next = '0;
        lead     = 1'b1;
        digit    = '0;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            digit = acc_q[4*k +: 4];
            if (digit != 4'd0) lead = 1'b0;
            if (ovf_next_q) begin
                seg_next[7*k +: 7] = SegDash;
            end else if (BLANK_LZ && lead && k != 0) begin
                seg_next[7*k +: 7] = SegBlank;
            end else begin
                seg_next[7*k +: 7] = seg_of(digit);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_q  <= '0;
            seg_q  <= SegReset;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= last;
            if (last) begin
                bcd_q <= acc_q;
                seg_q <= seg_next;
                ovf_q <= ovf_next_q;
            end
        end
    end

    // Output logic
    always_comb begin
        done = done_q;
        ovf  = ovf_q;
        bcd  = bcd_q;
        seg  = seg_q;
    end

endmodule
